register_unit: RTL and testbench

- General-purpose, parameterizable-width, clocked storage register with a write enable.
- Serves as the basic state element of the single-cycle processor datapath, e.g. as the program counter and for pipeline-free state holding.
- Loads its input on a rising clock edge when write is enabled. Otherwise it holds its value.
- Clears to zero on synchronous reset.

---
 rtl/register_unit.sv | 38 +++
 tb/tb_register_unit.sv | 113 +++++++++++
 2 files changed

// File: rtl/register_unit.sv
// General-purpose WIDTH-bit storage register with write enable and synchronous
// active-low reset; data_out is driven straight from the storage flops.
module register_unit #(
  parameter int unsigned          WIDTH       = 32,
  parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             wr,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Next-state: load on write, otherwise hold.
  always_comb begin
    data_d = data_q;
    if (wr) begin
      data_d = data_in;
    end else begin
      data_d = data_q;
    end
  end

  // Storage flops; reset wins over write at the same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_q <= RESET_VALUE;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_out = data_q;

endmodule

// File: tb/tb_register_unit.sv
// Self-checking bench for register_unit: directed plan plus randomized traffic
// compared against a behavioural model of the update rules.
module tb_register_unit;

  localparam int unsigned W = 32;

  logic          clk;
  logic          rst;
  logic [W-1:0]  data_in;
  logic          wr;
  logic [W-1:0]  data_out;

  int            total;
  int            bad;
  logic [W-1:0]  model;

  register_unit #(.WIDTH(W), .RESET_VALUE(32'h0000_0000)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .wr       (wr),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] exp);
    total++;
    assert (data_out === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, data_out, exp);
    end
  endtask

  // Called just after a falling edge: drive, cross one rising edge, return at falling edge.
  task automatic step(input logic r, input logic w, input logic [W-1:0] d);
    rst     = r;
    wr      = w;
    data_in = d;
    @(posedge clk);
    if (!r)     model = 32'h0000_0000;
    else if (w) model = d;
    @(negedge clk);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    model   = 32'hxxxx_xxxx;
    rst     = 1'b0;
    wr      = 1'b1;
    data_in = 32'hDEAD_BEEF;

    // Reset held two cycles with a pending write
    step(1'b0, 1'b1, 32'hDEAD_BEEF);
    check("reset_edge1", 32'h0000_0000);
    step(1'b0, 1'b1, 32'hDEAD_BEEF);
    check("reset_edge2", 32'h0000_0000);

    // Sequential writes 0,4,...,200
    for (int i = 0; i <= 50; i++) begin
      step(1'b1, 1'b1, 32'(i * 4));
      check("seq_write", 32'(i * 4));
    end
    check("seq_final", 32'd200);

    // Hold while data_in keeps moving
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 1'b0, 32'(200 + i * 4));
      check("hold", 32'd200);
    end

    // Reset mid-operation beats a simultaneous write, then recover
    step(1'b0, 1'b1, 32'd500);
    check("mid_reset", 32'h0000_0000);
    step(1'b1, 1'b1, 32'd12);
    check("post_reset_write", 32'd12);

    // Full-width bit-exact values
    step(1'b1, 1'b1, 32'hFFFF_FFFF);
    check("all_ones", 32'hFFFF_FFFF);
    step(1'b1, 1'b1, 32'h8000_0001);
    check("msb_lsb", 32'h8000_0001);

    // Reset pulse between edges must not disturb the stored value
    wr      = 1'b0;
    data_in = 32'h1234_5678;
    #2 rst  = 1'b0;
    #1 check("rst_pulse_no_comb", 32'h8000_0001);
    #1 rst  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_pulse_sync", 32'h8000_0001);
    model = 32'h8000_0001;

    // Randomized traffic against the behavioural model
    for (int i = 0; i < 300; i++) begin
      logic          r;
      logic          w;
      logic [W-1:0]  d;
      r = ($urandom_range(0, 7) != 0);
      w = ($urandom_range(0, 2) != 0);
      d = $urandom;
      step(r, w, d);
      check("random", model);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
